// File: rtl/core_pkg.sv
// Shared core-wide widths and the memory response record carried through
// the responder's latency pipeline.
package core_pkg;

    localparam int Xlen          = 32;
    localparam int MaskBits      = Xlen / 8;
    localparam int MaxMemLatency = 8;

    typedef struct packed {
        logic            valid;
        logic [Xlen-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/mem_sram.sv
// Word-organised storage with byte-masked synchronous write and a read port
// registered on the same edge that accepts the request.
module mem_sram #(
    parameter int DataW      = core_pkg::Xlen,
    parameter int MaskW      = core_pkg::MaskBits,
    parameter int DepthWords = 1024,
    localparam int IdxW      = $clog2(DepthWords)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IdxW-1:0]  idx,
    input  logic [DataW-1:0] wdata,
    input  logic [MaskW-1:0] wmask,
    output logic [DataW-1:0] rdata
);

    logic [DataW-1:0] mem [DepthWords];

    // Read returns the pre-write contents; the responder discards it for writes.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
        end
        if (we) begin
            for (int b = 0; b < MaskW; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the core's valid/ready request, rvalid response bus:
// configurable response latency and post-accept stall window.
module mem_responder #(
    parameter int Xlen        = core_pkg::Xlen,
    parameter int MaskBits    = core_pkg::MaskBits,
    parameter int DepthWords  = 1024,
    parameter int Latency     = 1,
    parameter int StallCycles = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Xlen-1:0]     addr_i,
    input  logic [Xlen-1:0]     wdata_i,
    input  logic [MaskBits-1:0] wmask_i,
    output logic [Xlen-1:0]     rdata_o,
    output logic                rvalid_o
);

    import core_pkg::*;

    localparam int IdxW = $clog2(DepthWords);
    localparam int CntW = (StallCycles > 0) ? $clog2(StallCycles + 1) : 1;

    typedef enum logic {
        READY,
        STALL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;

    logic            accept;
    logic            is_write;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic [Xlen-1:0] sram_rdata;
    logic            acc_p0;
    logic            keep_p0;
    mem_rsp_t        head;
    mem_rsp_t        tail;
    logic            unused_addr_lsb;

    assign accept          = valid_i && ready_o;
    assign is_write        = |wmask_i;
    assign in_range        = (addr_i[Xlen-1:IdxW+2] == '0);
    assign idx             = addr_i[IdxW+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    // Storage is never touched on an edge where reset is sampled.
    mem_sram #(
        .DataW      (Xlen),
        .MaskW      (MaskBits),
        .DepthWords (DepthWords)
    ) u_sram (
        .clk   (clk_i),
        .en    (accept && rst_ni),
        .we    (accept && rst_ni && is_write && in_range),
        .idx   (idx),
        .wdata (wdata_i),
        .wmask (wmask_i),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= STALL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Reset parks in STALL with an empty counter so ready rises one edge later.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_o    = 1'b0;
        case (state)
            READY: begin
                ready_o = 1'b1;
                if (valid_i && (StallCycles > 0)) begin
                    state_next = STALL;
                    cnt_next   = CntW'(StallCycles);
                end
            end
            STALL: begin
                if (cnt <= CntW'(1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CntW'(1);
                end
            end
            default: begin
                state_next = READY;
                cnt_next   = '0;
            end
        endcase
    end

    // Stage 0: response for the request accepted on the previous edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_p0  <= 1'b0;
            keep_p0 <= 1'b0;
        end else begin
            acc_p0  <= accept;
            keep_p0 <= accept && !is_write && in_range;
        end
    end

    always_comb begin
        head.valid = acc_p0;
        head.data  = keep_p0 ? sram_rdata : '0;
    end

    // Stages 1..Latency-1: plain shift register, valid bits cleared by reset
    if (Latency > 1) begin : g_pipe
        mem_rsp_t stages [Latency-1];

        always_ff @(posedge clk_i) begin
            stages[0] <= head;
            for (int k = 1; k < Latency - 1; k++) begin
                stages[k] <= stages[k-1];
            end
            if (!rst_ni) begin
                for (int k = 0; k < Latency - 1; k++) begin
                    stages[k].valid <= 1'b0;
                end
            end
        end

        assign tail = stages[Latency-2];
    end else begin : g_direct
        assign tail = head;
    end

    assign rvalid_o = tail.valid;
    assign rdata_o  = tail.valid ? tail.data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances cover latency 1/3/4 and a
// two-cycle stall window, each exercised in turn on a shared request bus.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;

    logic        v1, v3, vs, v4;
    logic        rdy1, rdy3, rdys, rdy4;
    logic        rv1, rv3, rvs, rv4;
    logic [31:0] rd1, rd3, rds, rd4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.Latency(1), .StallCycles(0)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd1), .rvalid_o(rv1));

    mem_responder #(.Latency(3), .StallCycles(0)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(rdy3), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd3), .rvalid_o(rv3));

    mem_responder #(.Latency(1), .StallCycles(2)) u_s2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vs), .ready_o(rdys), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rds), .rvalid_o(rvs));

    mem_responder #(.Latency(4), .StallCycles(0)) u_l4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .ready_o(rdy4), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd4), .rvalid_o(rv4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
    endtask

    int acc;
    int exp_rdy [6] = '{1, 0, 0, 1, 0, 0};

    initial begin
        rst_n = 1'b0;
        v1 = 1'b1; v3 = 1'b1; vs = 1'b1; v4 = 1'b1;
        drive(32'h0, 32'h0, 4'h0);
        @(negedge clk);

        repeat (3) begin
            tick;
            check("rst_ready", {31'b0, rdy1 | rdy3 | rdys | rdy4}, 32'd0);
            check("rst_rvalid", {31'b0, rv1 | rv3 | rvs | rv4}, 32'd0);
        end
        check("rst_rdata", rd1 | rd3 | rds | rd4, 32'd0);

        v3 = 1'b0; vs = 1'b0; v4 = 1'b0;
        rst_n = 1'b1;
        tick;
        check("bringup_ready_l1", {31'b0, rdy1}, 32'd1);
        check("bringup_ready_s2", {31'b0, rdys}, 32'd1);
        check("bringup_rvalid", {31'b0, rv1}, 32'd0);

        // Write / readback at latency 1
        drive(32'h10, 32'hDEADBEEF, 4'hF);
        tick;
        check("wr_rvalid", {31'b0, rv1}, 32'd1);
        check("wr_rdata", rd1, 32'd0);
        drive(32'h10, 32'h0, 4'h0);
        tick;
        check("rd_rvalid", {31'b0, rv1}, 32'd1);
        check("rd_rdata", rd1, 32'hDEADBEEF);

        // Byte mask
        drive(32'h10, 32'h000000AA, 4'h1);
        tick;
        check("bwr_rdata", rd1, 32'd0);
        drive(32'h10, 32'hFFFFFFFF, 4'h0);
        tick;
        check("bmask_rdata", rd1, 32'hDEADBEAA);
        drive(32'h10, 32'h0, 4'h0);
        tick;
        check("zero_mask_is_read", rd1, 32'hDEADBEAA);
        v1 = 1'b0;
        tick;
        check("idle_rvalid", {31'b0, rv1}, 32'd0);
        check("idle_rdata", rd1, 32'd0);

        // Pipelining at latency 3
        v3 = 1'b1;
        drive(32'h0, 32'd1, 4'hF); tick;
        drive(32'h4, 32'd2, 4'hF); tick;
        drive(32'h8, 32'd3, 4'hF); tick;
        v3 = 1'b0;
        repeat (4) tick;
        check("l3_ready", {31'b0, rdy3}, 32'd1);
        check("l3_drained", {31'b0, rv3}, 32'd0);
        v3 = 1'b1;
        drive(32'h0, 32'h0, 4'h0); tick;
        check("l3_lat_a", {31'b0, rv3}, 32'd0);
        drive(32'h4, 32'h0, 4'h0); tick;
        check("l3_lat_b", {31'b0, rv3}, 32'd0);
        drive(32'h8, 32'h0, 4'h0); tick;
        check("l3_rv0", {31'b0, rv3}, 32'd1);
        check("l3_rd0", rd3, 32'd1);
        v3 = 1'b0;
        tick;
        check("l3_rv1", {31'b0, rv3}, 32'd1);
        check("l3_rd1", rd3, 32'd2);
        tick;
        check("l3_rv2", {31'b0, rv3}, 32'd1);
        check("l3_rd2", rd3, 32'd3);
        tick;
        check("l3_rv_end", {31'b0, rv3}, 32'd0);

        // Stall window of two cycles with valid held high
        vs = 1'b1;
        drive(32'h0, 32'h0, 4'h0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            check("stall_ready", {31'b0, rdys}, exp_rdy[i]);
            tick;
            if (rvs) acc++;
        end
        vs = 1'b0;
        check("stall_accepts", acc, 32'd2);

        // Reset two cycles after a latency-4 accept, with a write on the reset edge
        v4 = 1'b1;
        drive(32'h10, 32'h0, 4'h0);
        tick;
        v4 = 1'b0;
        tick;
        rst_n = 1'b0;
        v1 = 1'b1;
        drive(32'h10, 32'h12345678, 4'hF);
        tick;
        check("midrst_rv_a", {31'b0, rv4}, 32'd0);
        v1 = 1'b0;
        tick;
        check("midrst_rv_b", {31'b0, rv4}, 32'd0);
        rst_n = 1'b1;
        acc = 0;
        repeat (4) begin
            tick;
            if (rv4) acc++;
        end
        check("midrst_no_rsp", acc, 32'd0);

        // Out-of-range accesses
        check("oor_ready", {31'b0, rdy1}, 32'd1);
        v1 = 1'b1;
        drive(32'h0, 32'h11223344, 4'hF); tick;
        drive(32'h1000, 32'h0, 4'h0); tick;
        check("oor_rd_rvalid", {31'b0, rv1}, 32'd1);
        check("oor_rd_rdata", rd1, 32'd0);
        drive(32'h1000, 32'hFFFFFFFF, 4'hF); tick;
        check("oor_wr_rvalid", {31'b0, rv1}, 32'd1);
        check("oor_wr_rdata", rd1, 32'd0);
        drive(32'h0, 32'h0, 4'h0); tick;
        check("oor_word0_kept", rd1, 32'h11223344);
        drive(32'h10, 32'h0, 4'h0); tick;
        check("rst_edge_write_dropped", rd1, 32'hDEADBEAA);
        v1 = 1'b0;
        tick;
        check("final_idle", {31'b0, rv1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port, byte-masked memory model that acts as the responder on the core's valid/ready request, rvalid response memory interface.
- Two instances sit in the SoC/testbench top: one on the instmem port, one on the datamem port.
- Response latency is configurable, and a stall pattern is configurable, so fetch and LSU handshakes can be exercised under back-pressure.

Parameters:
- Xlen, core_pkg::Xlen (32), data/address width.
- MaskBits, core_pkg::MaskBits (Xlen/8), byte-enable width.
- DepthWords, 1024, storage depth in Xlen-bit words (power of two).
- Latency, 1, cycles from request acceptance to rvalid_o (legal range 1..8).
- StallCycles, 0, cycles ready_o stays low after each accepted request (0 = full throughput).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- valid_i  in  1  request valid from initiator
- ready_o  out  1  responder can accept request this cycle
- addr_i  in  Xlen  byte address
- wdata_i  in  Xlen  write data
- wmask_i  in  MaskBits  byte enables; all-zero = read, nonzero = write
- rdata_o  out  Xlen  response data
- rvalid_o  out  1  response valid, single-cycle pulse per accepted request

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low: rst_ni sampled low at a clk_i edge resets the block.
- Reset values: ready_o=0, rvalid_o=0, rdata_o=0, stall counter=0, response pipeline empty. Storage contents are not reset.
- ready_o rises in the first cycle after rst_ni is sampled high.
- Accept: a request is accepted on a rising edge where valid_i && ready_o. No other cycle has any effect on storage.
- Address map:
  - word index = addr_i[log2(DepthWords)+1:2]; addr_i[1:0] ignored (aligned access only).
  - addr_i >= DepthWords*4 is out of range.
- Write (wmask_i != 0):
  - For each set bit b, byte b of the word is replaced by wdata_i[8b+7:8b]; unmasked bytes are unchanged.
  - The update is visible to any request accepted on the next edge or later.
  - A write still produces one response, with rdata_o=0.
- Read (wmask_i == 0): the word is sampled at the accepting edge and returned Latency cycles later.
- Latency: a request accepted at edge N gives rvalid_o=1 with its rdata_o during the cycle after edge N+Latency-1. Latency=1 means rvalid_o is high in the cycle right after acceptance.
- Response pipeline:
  - Shift register of Latency stages, each holding {valid, data}. There is no response back-pressure.
  - In-order, one response per accepted request.
  - Back-to-back requests give back-to-back rvalid_o pulses.
- rdata_o when rvalid_o=0: rdata_o is driven 0, not stale data.
- Out of range: a write is dropped and still responds with 0; a read returns 0.
- Stall FSM:
  - States READY and STALL.
  - READY: ready_o=1. On accept with StallCycles>0, load counter=StallCycles and go to STALL.
  - STALL: ready_o=0, decrement counter each cycle, return to READY the cycle after the counter reaches 1.
  - StallCycles=0: the block never leaves READY.
- ready_o does not depend combinationally on valid_i.
- Simultaneous events: while a response is emitted, a new request may be accepted in the same cycle; the two are independent.
- Reset mid-operation: in-flight responses are discarded (no rvalid_o after reset). A write accepted on the same edge that rst_ni is sampled low is not performed.

Decomposition:
- core_pkg: reuse Xlen and MaskBits. Add a packed struct mem_rsp_t {logic valid; logic [Xlen-1:0] data} for the pipeline stages, plus constant MaxMemLatency=8.
- Sub-module mem_sram: DepthWords x Xlen storage with byte-masked synchronous write and synchronous read at the accept edge. mem_responder owns the handshake, stall FSM and latency pipeline.

Test Plan:
- Reset/bring-up: hold rst_ni=0 for 3 cycles with valid_i=1 -> ready_o=0, rvalid_o=0 throughout; ready_o=1 in the first cycle after release.
- Write/readback, Latency=1: write 0xDEADBEEF to 0x10 with wmask=0xF, then read 0x10 -> read rvalid_o one cycle after its accept, rdata_o=0xDEADBEEF; the write response carries 0.
- Byte mask: at 0x10 write 0x000000AA with wmask=0x1, then read 0x10 -> 0xDEADBEAA; wmask=0x0 with wdata=0xFFFFFFFF acts as a read and leaves the word unchanged.
- Pipelining: Latency=3, StallCycles=0, reads of 0x0, 0x4, 0x8 on consecutive edges (preloaded 1, 2, 3) -> rvalid_o high for 3 consecutive cycles, rdata_o=1, 2, 3, with the first pulse 3 cycles after the first accept.
- Stall FSM: StallCycles=2, valid_i held high -> ready_o pattern 1,0,0,1,0,0; exactly one accept per 3 cycles.
- Reset mid-flight plus out of range: Latency=4, accept a read, assert rst_ni=0 two cycles later -> no rvalid_o. Then, with DepthWords=1024, read 0x1000 -> rvalid_o with rdata_o=0, and a write to 0x1000 leaves word 0 unchanged.
